adc_serial_writer: RTL

//   Write-only serial initiator for the ADC control port (ADC_SCLK / ADC_SDATA / ADC_SCS), today tied off.

---
 rtl/adc_serial_writer_if.sv | 22 ++
 rtl/adc_serial_writer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/adc_serial_writer_if.sv
// Command-side handshake and ADC control-pin bundle for adc_serial_writer.
// The master modport is the command logic; the slave modport is the writer.
interface adc_serial_writer_if;
  logic        Start;
  logic [3:0]  Addr;
  logic [15:0] Data;
  logic        Busy;
  logic        Done;
  logic        ADC_SCLK;
  logic        ADC_SDATA;
  logic        ADC_SCS;

  modport master (
    output Start, Addr, Data,
    input  Busy, Done, ADC_SCLK, ADC_SDATA, ADC_SCS
  );

  modport slave (
    input  Start, Addr, Data,
    output Busy, Done, ADC_SCLK, ADC_SDATA, ADC_SCS
  );
endinterface

// File: rtl/adc_serial_writer.sv
// Write-only serial initiator for the ADC control port.
// Sends one 32-bit frame {HEADER, Addr, Data} MSB first on ADC_SCLK/ADC_SDATA
// framed by active-low ADC_SCS, then holds SCS high for CS_GAP cycles.
module adc_serial_writer #(
  parameter int unsigned CLK_DIV = 5,
  parameter int unsigned CS_GAP  = 10,
  parameter logic [11:0] HEADER  = 12'h001
) (
  input logic                Clock,
  input logic                Reset,
  adc_serial_writer_if.slave bus
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]       state_q, state_d;
  // Bits still to be sent after the one currently on SDATA, next bit at [30].
  logic [30:0]      shreg_q, shreg_d;
  logic [4:0]       bit_q,   bit_d;
  logic [DIV_W-1:0] div_q,   div_d;
  logic [GAP_W-1:0] gap_q,   gap_d;
  logic             sclk_q,  sclk_d;
  logic             sdata_q, sdata_d;
  logic             scs_q,   scs_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             div_wrap;

  assign div_wrap = (div_q == DIV_LAST);

  // Next-state logic for the frame sequencer and pin registers.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    div_d   = div_q;
    gap_d   = gap_q;
    sclk_d  = sclk_q;
    sdata_d = sdata_q;
    scs_d   = scs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          shreg_d = {HEADER[10:0], bus.Addr, bus.Data};
          sdata_d = HEADER[11];
          sclk_d  = 1'b0;
          scs_d   = 1'b0;
          bit_d   = 5'd31;
          div_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (div_wrap) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q != 5'd0) begin
              sdata_d = shreg_q[30];
              shreg_d = {shreg_q[29:0], 1'b0};
              bit_d   = bit_q - 5'd1;
            end else begin
              sdata_d = 1'b0;
              state_d = S_HOLD;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (div_wrap) begin
          div_d   = '0;
          gap_d   = '0;
          scs_d   = 1'b1;
          state_d = S_GAP;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      gap_q   <= '0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      scs_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      scs_q   <= scs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.ADC_SCLK  = sclk_q;
  assign bus.ADC_SDATA = sdata_q;
  assign bus.ADC_SCS   = scs_q;

endmodule
